// File: rtl/coo_edge_fetcher_pkg.sv
// Shared types and constants for the COO edge fetcher: COO geometry, node index width,
// FSM state encoding and the registered edge record.
package gcn_pkg;

  localparam int COO_NUM_OF_COLS = 6;
  localparam int COO_NUM_OF_ROWS = 2;

  function automatic int coo_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COO_BW  = coo_bw(COO_NUM_OF_COLS);
  localparam int SRC_ROW = 0;
  localparam int DST_ROW = 1;

  typedef logic [COO_BW-1:0] node_t;

  localparam node_t LAST_COL = node_t'(COO_NUM_OF_COLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } coo_fetch_state_t;

  typedef struct packed {
    node_t src;
    node_t dst;
    node_t idx;
  } coo_edge_t;

endpackage

// File: rtl/coo_edge_fetcher_if.sv
// Edge stream from the fetcher to the aggregation engine (valid/ready handshake).
interface coo_edge_fetcher_if;
  import gcn_pkg::*;

  logic  edge_valid;
  logic  edge_ready;
  node_t edge_src;
  node_t edge_dst;
  node_t edge_idx;

  modport master (output edge_valid, edge_src, edge_dst, edge_idx, input edge_ready);
  modport slave  (input edge_valid, edge_src, edge_dst, edge_idx, output edge_ready);

endinterface

// File: rtl/coo_lat_delay.sv
// Delays the COO read strobe by the memory latency; the output marks the cycle
// on which coo_in carries the requested column.
module coo_lat_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic capture
);

  logic [DEPTH-1:0] pipe;

  // NOTE: non-blocking assignments let every stage sample its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= strobe;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign capture = pipe[DEPTH-1];

endmodule

// File: rtl/coo_edge_fetcher.sv
// Walks the COO columns once per start: reads each column, presents it as an edge,
// and steps the shared row counter on every accepted edge.
module coo_edge_fetcher
  import gcn_pkg::*;
#(
  parameter int NUM_OF_NODES = 6,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  node_t                              coo_address,
  output logic                               enable_count,
  output logic                               enable_read_coo,
  output node_t                              read_address_coo,
  input  node_t [COO_NUM_OF_ROWS-1:0]        coo_in,
  coo_edge_fetcher_if.master                 edge_bus,
  output logic                               busy,
  output logic                               done,
  output logic                               err_range,
  output logic                               err_sync
);

  coo_fetch_state_t state, state_next;
  coo_edge_t        edge_q;
  node_t            edge_cnt;
  node_t            issue_addr;
  logic             edge_valid_q;
  logic             handshake;
  logic             capture;

  assign handshake = edge_valid_q && edge_bus.edge_ready;

  coo_lat_delay #(.DEPTH(MEM_LATENCY)) u_lat_delay (
    .clk     (clk),
    .reset   (reset),
    .strobe  (enable_read_coo),
    .capture (capture)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next       = state;
    enable_read_coo  = 1'b0;
    read_address_coo = '0;
    enable_count     = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        enable_read_coo  = 1'b1;
        read_address_coo = coo_address;
        state_next       = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture) state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (handshake) begin
          enable_count = 1'b1;
          state_next   = (edge_cnt == LAST_COL) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q       <= '0;
      edge_cnt     <= '0;
      issue_addr   <= '0;
      edge_valid_q <= 1'b0;
      err_range    <= 1'b0;
      err_sync     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            edge_cnt  <= '0;
            err_range <= 1'b0;
            err_sync  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          issue_addr <= coo_address;
          if (coo_address != edge_cnt) err_sync <= 1'b1;
        end
        ST_WAIT: begin
          if (capture) begin
            edge_q       <= '{src: coo_in[SRC_ROW], dst: coo_in[DST_ROW], idx: issue_addr};
            edge_valid_q <= 1'b1;
            // Out-of-range nodes are flagged but still delivered downstream.
            if (int'(coo_in[SRC_ROW]) >= NUM_OF_NODES || int'(coo_in[DST_ROW]) >= NUM_OF_NODES)
              err_range <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (handshake) begin
            edge_valid_q <= 1'b0;
            edge_cnt     <= (edge_cnt == LAST_COL) ? '0 : edge_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign edge_bus.edge_valid = edge_valid_q;
  assign edge_bus.edge_src   = edge_q.src;
  assign edge_bus.edge_dst   = edge_q.dst;
  assign edge_bus.edge_idx   = edge_q.idx;

endmodule

// File: tb/tb_coo_edge_fetcher.sv
// Directed bench: row counter and COO memory models around a MEM_LATENCY=1 and a MEM_LATENCY=3 fetcher.
module tb_coo_edge_fetcher;
  import gcn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  node_t mem_src [6];
  node_t mem_dst [6];

  // ML=1 instance
  logic  start1 = 1'b0, bump1 = 1'b0;
  logic  en_cnt1, rd1, busy1, done1, erng1, esync1;
  node_t cnt1, addr1;
  node_t [1:0] coo_in1;
  coo_edge_fetcher_if e1 ();

  // ML=3 instance
  logic  start3 = 1'b0;
  logic  en_cnt3, rd3, busy3, done3, erng3, esync3;
  node_t cnt3, addr3;
  node_t [1:0] coo_in3, p0_3, p1_3;
  coo_edge_fetcher_if e3 ();

  int pulses1 = 0, dones1 = 0, pulses3 = 0, dones3 = 0;

  coo_edge_fetcher #(.NUM_OF_NODES(6), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .coo_address(cnt1),
    .enable_count(en_cnt1), .enable_read_coo(rd1), .read_address_coo(addr1),
    .coo_in(coo_in1), .edge_bus(e1.master), .busy(busy1), .done(done1),
    .err_range(erng1), .err_sync(esync1)
  );

  coo_edge_fetcher #(.NUM_OF_NODES(6), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .coo_address(cnt3),
    .enable_count(en_cnt3), .enable_read_coo(rd3), .read_address_coo(addr3),
    .coo_in(coo_in3), .edge_bus(e3.master), .busy(busy3), .done(done3),
    .err_range(erng3), .err_sync(esync3)
  );

  // Row counters (wrap at 6) and COO memories
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt1 <= '0; cnt3 <= '0; coo_in1 <= '0; coo_in3 <= '0; p0_3 <= '0; p1_3 <= '0;
    end else begin
      if (en_cnt1 || bump1) cnt1 <= (cnt1 == 3'd5) ? 3'd0 : cnt1 + 3'd1;
      if (en_cnt3)          cnt3 <= (cnt3 == 3'd5) ? 3'd0 : cnt3 + 3'd1;
      if (rd1) coo_in1 <= {mem_dst[addr1], mem_src[addr1]};
      if (rd3) p0_3 <= {mem_dst[addr3], mem_src[addr3]};
      p1_3    <= p0_3;
      coo_in3 <= p1_3;
    end
  end

  always @(posedge clk) begin
    if (en_cnt1) pulses1 <= pulses1 + 1;
    if (done1)   dones1  <= dones1 + 1;
    if (en_cnt3) pulses3 <= pulses3 + 1;
    if (done3)   dones3  <= dones3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid1(output int t);
    t = 0;
    while (!e1.edge_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("valid1_seen", e1.edge_valid, 1);
  endtask

  // Full pass on the ML=1 instance; counter assumed at 0 before start.
  task automatic run_pass1(input int hold_edge, input bit bad_col4);
    int t, p0, d0;
    p0 = pulses1;
    d0 = dones1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check("issue_busy", busy1, 1);
    check("issue_rd", rd1, 1);
    check("issue_addr", addr1, 0);
    check("start_clr_range", erng1, 0);
    check("start_clr_sync", esync1, 0);
    for (int e = 0; e < 6; e++) begin
      if (e == hold_edge) e1.edge_ready = 1'b0;
      wait_valid1(t);
      if (e == 0) check("first_latency", t, 2);
      check("src", e1.edge_src, (bad_col4 && e == 4) ? 6 : e);
      check("dst", e1.edge_dst, (e + 1) % 6);
      check("idx", e1.edge_idx, e);
      check("range_flag", erng1, (bad_col4 && e >= 4) ? 1 : 0);
      if (e == hold_edge) begin
        repeat (4) begin
          check("hold_no_count", en_cnt1, 0);
          @(negedge clk);
          check("hold_valid", e1.edge_valid, 1);
          check("hold_src", e1.edge_src, e);
          check("hold_dst", e1.edge_dst, (e + 1) % 6);
        end
        e1.edge_ready = 1'b1;
        #1;
      end
      check("hs_count", en_cnt1, 1);
      @(negedge clk);
      check("valid_drop", e1.edge_valid, 0);
    end
    check("done_pulse", done1, 1);
    check("done_busy", busy1, 1);
    @(negedge clk);
    check("done_low", done1, 0);
    check("idle_busy", busy1, 0);
    check("count_pulses", pulses1 - p0, 6);
    check("done_pulses", dones1 - d0, 1);
    check("counter_wrap", cnt1, 0);
    check("range_end", erng1, bad_col4 ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0, p0;
    for (int i = 0; i < 6; i++) begin
      mem_src[i] = node_t'(i);
      mem_dst[i] = node_t'((i + 1) % 6);
    end
    e1.edge_ready = 1'b1;
    e3.edge_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", e1.edge_valid, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_cnt_en", en_cnt1, 0);
    check("rst_rd", rd1, 0);
    check("rst_errs", {erng1, esync1}, 0);
    reset = 1'b0;

    // Plain pass, then hold on edge 2 with bad src on column 4, then clean pass
    run_pass1(-1, 1'b0);
    mem_src[4] = node_t'(6);
    run_pass1(2, 1'b1);
    mem_src[4] = node_t'(4);
    run_pass1(-1, 1'b0);

    // Counter pre-advanced to 3 -> sync error at first issue
    @(negedge clk) bump1 = 1'b1;
    repeat (3) @(negedge clk);
    bump1 = 1'b0;
    check("bump_cnt", cnt1, 3);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check("sync_addr", addr1, 3);
    check("sync_pre", esync1, 0);
    @(negedge clk);
    check("sync_set", esync1, 1);
    t = 0;
    while (!done1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("sync_done", done1, 1);
    check("sync_sticky", esync1, 1);
    @(negedge clk);
    check("sync_cnt_end", cnt1, 3);
    bump1 = 1'b1;
    repeat (3) @(negedge clk);
    bump1 = 1'b0;
    check("rebump_cnt", cnt1, 0);

    // Reset while edge 3 is presented
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int e = 0; e < 3; e++) begin
      wait_valid1(t);
      @(negedge clk);
    end
    e1.edge_ready = 1'b0;
    wait_valid1(t);
    check("pre_rst_idx", e1.edge_idx, 3);
    d0 = dones1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", e1.edge_valid, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_src", e1.edge_src, 0);
    check("mid_rst_outs", {en_cnt1, rd1, done1}, 0);
    check("mid_rst_cnt", cnt1, 0);
    @(negedge clk) reset = 1'b0;
    check("mid_rst_nodone", dones1 - d0, 0);
    e1.edge_ready = 1'b1;
    run_pass1(-1, 1'b0);

    // ML=3 instance: extra start while busy is ignored, latency 4
    d0 = dones3;
    p0 = pulses3;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    t = 2;
    while (!e3.edge_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ml3_latency", t, 4);
    for (int e = 0; e < 6; e++) begin
      t = 0;
      while (!e3.edge_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("ml3_idx", e3.edge_idx, e);
      check("ml3_src", e3.edge_src, e);
      check("ml3_dst", e3.edge_dst, (e + 1) % 6);
      @(negedge clk);
    end
    check("ml3_done", done3, 1);
    repeat (5) @(negedge clk);
    check("ml3_idle", busy3, 0);
    check("ml3_dones", dones3 - d0, 1);
    check("ml3_pulses", pulses3 - p0, 6);
    check("ml3_cnt", cnt3, 0);
    check("ml3_errs", {erng3, esync3}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
